// File: rtl/photo_interrupter_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : photo_interrupter_ctrl_if
// Brief   : Signal bundle between the photo-interrupter controller and its user.
// Revision: 1.0 - initial release
// ============================================================================
interface photo_interrupter_ctrl_if #(
    parameter int CNT_W = 16,
    parameter int PER_W = 24
);
    logic             enable;
    logic             sensor;
    logic             clear;
    logic             led;
    logic             event_pulse;
    logic [CNT_W-1:0] event_count;
    logic [PER_W-1:0] period;
    logic             period_valid;
    logic             stalled;

    modport master (
        output enable, sensor, clear,
        input  led, event_pulse, event_count, period, period_valid, stalled
    );

    modport slave (
        input  enable, sensor, clear,
        output led, event_pulse, event_count, period, period_valid, stalled
    );
endinterface
`default_nettype wire

// File: rtl/photo_interrupter_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : photo_interrupter_ctrl
// Brief   : Sync + debounce of a slotted photo-interrupter, event counting and
//           inter-event period measurement. Optional stall detection is built
//           when PI_STALL_DETECT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module photo_interrupter_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16,
    parameter int PER_W           = 24,
    parameter int TIMEOUT_CYCLES  = 1000000
) (
    input  wire                        clk,
    input  wire                        rst,
    photo_interrupter_ctrl_if.slave    bus
);

    localparam int C_DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [C_DEB_W-1:0] C_DEB_MAX = C_DEB_W'(DEBOUNCE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLR      = 3'd1,
        S_CONF_BLK = 3'd2,
        S_BLK      = 3'd3,
        S_CONF_CLR = 3'd4
    } state_t;

    state_t             r_state;
    logic               r_sync1;
    logic               r_sync2;
    logic [C_DEB_W-1:0] r_deb_cnt;
    logic               r_led;
    logic               r_event_pulse;
    logic [CNT_W-1:0]   r_count;
    logic [PER_W-1:0]   r_timer;
    logic [PER_W-1:0]   r_period;
    logic               r_period_valid;
    logic               r_have_evt;
    logic               r_stalled;

    logic               w_s_sync;
    logic [C_DEB_W-1:0] w_deb_next;
    logic               w_deb_done;
    logic               w_evt;
    logic [PER_W-1:0]   w_timer_inc;

    assign w_s_sync    = r_sync2;
    assign w_deb_next  = r_deb_cnt + 1'b1;
    assign w_deb_done  = (w_deb_next >= C_DEB_MAX);
    assign w_evt       = bus.enable && (r_state == S_CONF_BLK) && w_s_sync && w_deb_done;
    assign w_timer_inc = (r_timer == '1) ? r_timer : r_timer + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.sensor;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce FSM; led and event_pulse are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_deb_cnt     <= '0;
            r_led         <= 1'b0;
            r_event_pulse <= 1'b0;
        end else if (!bus.enable) begin
            r_state       <= S_IDLE;
            r_deb_cnt     <= '0;
            r_led         <= 1'b0;
            r_event_pulse <= 1'b0;
        end else begin
            r_event_pulse <= w_evt;
            case (r_state)
                S_IDLE: begin
                    r_state   <= w_s_sync ? S_BLK : S_CLR;
                    r_led     <= w_s_sync;
                    r_deb_cnt <= '0;
                end
                S_CLR: begin
                    r_led <= 1'b0;
                    if (w_s_sync) begin
                        r_state   <= S_CONF_BLK;
                        r_deb_cnt <= C_DEB_W'(1);
                    end
                end
                S_CONF_BLK: begin
                    if (!w_s_sync) begin
                        r_state   <= S_CLR;
                        r_deb_cnt <= '0;
                        r_led     <= 1'b0;
                    end else if (w_deb_done) begin
                        r_state   <= S_BLK;
                        r_deb_cnt <= '0;
                        r_led     <= 1'b1;
                    end else begin
                        r_deb_cnt <= w_deb_next;
                        r_led     <= 1'b0;
                    end
                end
                S_BLK: begin
                    r_led <= 1'b1;
                    if (!w_s_sync) begin
                        r_state   <= S_CONF_CLR;
                        r_deb_cnt <= C_DEB_W'(1);
                    end
                end
                S_CONF_CLR: begin
                    if (w_s_sync) begin
                        r_state   <= S_BLK;
                        r_deb_cnt <= '0;
                        r_led     <= 1'b1;
                    end else if (w_deb_done) begin
                        r_state   <= S_CLR;
                        r_deb_cnt <= '0;
                        r_led     <= 1'b0;
                    end else begin
                        r_deb_cnt <= w_deb_next;
                        r_led     <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_deb_cnt <= '0;
                    r_led     <= 1'b0;
                end
            endcase
        end
    end

    // A clear coinciding with an event is applied first, so that event counts as the first one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count        <= '0;
            r_timer        <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_have_evt     <= 1'b0;
        end else begin
            r_period_valid <= w_evt && r_have_evt && !bus.clear;

            if (w_evt)
                r_count <= (bus.clear ? '0 : r_count) + 1'b1;
            else if (bus.clear)
                r_count <= '0;

            if (bus.clear)
                r_period <= '0;
            else if (w_evt && r_have_evt)
                r_period <= w_timer_inc;

            if (w_evt) begin
                r_timer    <= '0;
                r_have_evt <= 1'b1;
            end else if (bus.clear) begin
                r_timer    <= '0;
                r_have_evt <= 1'b0;
            end else if (bus.enable) begin
                r_timer <= w_timer_inc;
            end
        end
    end

`ifdef PI_STALL_DETECT_EN
    localparam logic [PER_W-1:0] C_TIMEOUT = PER_W'(TIMEOUT_CYCLES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stalled <= 1'b0;
        else
            r_stalled <= bus.enable && !bus.clear && !w_evt && r_have_evt
                         && (r_timer >= C_TIMEOUT);
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign r_stalled        = 1'b0;
`endif

    assign bus.led          = r_led;
    assign bus.event_pulse  = r_event_pulse;
    assign bus.event_count  = r_count;
    assign bus.period       = r_period;
    assign bus.period_valid = r_period_valid;
    assign bus.stalled      = r_stalled;

endmodule
`default_nettype wire

// File: tb/tb_photo_interrupter_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_photo_interrupter_ctrl
// Brief   : Scoreboard bench for photo_interrupter_ctrl (narrow count to reach wrap).
// Revision: 1.0 - initial release
// ============================================================================
module tb_photo_interrupter_ctrl;

    localparam int C_DEB  = 16;
    localparam int C_CW   = 4;
    localparam int C_PW   = 24;
    localparam int C_TOUT = 500;

    typedef struct {
        logic [C_CW-1:0] cnt;
        logic            pv;
        logic [C_PW-1:0] per;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    photo_interrupter_ctrl_if #(.CNT_W(C_CW), .PER_W(C_PW)) bus ();

    photo_interrupter_ctrl #(
        .DEBOUNCE_CYCLES (C_DEB),
        .CNT_W           (C_CW),
        .PER_W           (C_PW),
        .TIMEOUT_CYCLES  (C_TOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every event pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.event_pulse) begin
                if (sb.size() == 0) begin
                    check("unexpected_event", 32'(bus.event_pulse), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("event_count", 32'(bus.event_count), 32'(e.cnt));
                    check("period_valid", 32'(bus.period_valid), 32'(e.pv));
                    if (e.pv)
                        check("period", 32'(bus.period), 32'(e.per));
                end
            end else if (bus.period_valid) begin
                check("stray_period_valid", 32'(bus.period_valid), 32'd0);
            end
        end
    end

    // Holds sensor low, raises it, waits for the event; sensor rise to pulse must be 18 edges.
    task automatic do_event(input int low_cycles, input logic [C_CW-1:0] cnt,
                            input logic pv, input logic [C_PW-1:0] per, input bit with_clear);
        exp_t e;
        int   lat;
        bit   found;
        e.cnt = cnt;
        e.pv  = pv;
        e.per = per;
        sb.push_back(e);
        bus.sensor = 1'b0;
        repeat (low_cycles) @(negedge clk);
        bus.sensor = 1'b1;
        lat   = 0;
        found = 1'b0;
        while (!found && lat < 40) begin
            @(negedge clk);
            lat++;
            bus.clear = with_clear && (lat == C_DEB + 1);
            if (bus.event_pulse)
                found = 1'b1;
        end
        bus.clear = 1'b0;
        check("event_latency", 32'(lat), 32'(C_DEB + 2));
        check("led_on_event", 32'(bus.led), 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        bus.enable = 1'b0;
        bus.sensor = 1'b1;
        bus.clear  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_led", 32'(bus.led), 32'd0);
        check("rst_pulse", 32'(bus.event_pulse), 32'd0);
        check("rst_count", 32'(bus.event_count), 32'd0);
        check("rst_period", 32'(bus.period), 32'd0);
        check("rst_pv", 32'(bus.period_valid), 32'd0);
        check("rst_stalled", 32'(bus.stalled), 32'd0);

        // Enable only after the synchroniser holds sensor=1: IDLE goes straight to BLK.
        rst = 1'b0;
        repeat (3) @(negedge clk);
        bus.enable = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_to_blk_led", 32'(bus.led), 32'd1);
        check("idle_to_blk_count", 32'(bus.event_count), 32'd0);

        bus.sensor = 1'b0;
        repeat (25) @(negedge clk);
        check("release_led", 32'(bus.led), 32'd0);

        // 10-cycle glitch must be rejected.
        bus.sensor = 1'b1;
        repeat (10) @(negedge clk);
        bus.sensor = 1'b0;
        repeat (30) @(negedge clk);
        check("glitch_led", 32'(bus.led), 32'd0);
        check("glitch_count", 32'(bus.event_count), 32'd0);

        do_event(0, 4'd1, 1'b0, '0, 1'b0);
        do_event(982, 4'd2, 1'b1, 24'd1000, 1'b0);

        repeat (450) @(negedge clk);
        check("stall_early", 32'(bus.stalled), 32'd0);
        repeat (70) @(negedge clk);
`ifdef PI_STALL_DETECT_EN
        check("stall_set", 32'(bus.stalled), 32'd1);
`else
        check("stall_tied", 32'(bus.stalled), 32'd0);
`endif
        do_event(30, 4'd3, 1'b1, 24'd568, 1'b0);
        check("stall_cleared", 32'(bus.stalled), 32'd0);

        for (int i = 4; i <= 16; i++)
            do_event(30, C_CW'(i), 1'b1, 24'd48, 1'b0);
        check("wrap_count", 32'(bus.event_count), 32'd0);

        do_event(30, 4'd1, 1'b0, '0, 1'b1);
        @(negedge clk);
        check("clear_evt_period", 32'(bus.period), 32'd0);
        check("clear_evt_count", 32'(bus.event_count), 32'd1);
        do_event(29, 4'd2, 1'b1, 24'd48, 1'b0);

        bus.enable = 1'b0;
        repeat (3) @(negedge clk);
        check("disable_led", 32'(bus.led), 32'd0);
        check("disable_count_hold", 32'(bus.event_count), 32'd2);
        check("disable_period_hold", 32'(bus.period), 32'd48);

        repeat (5) @(negedge clk);
        check("sb_leftover", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
